// File: rtl/jtopl_opacc.sv
// jtopl_opacc: operator output accumulator.
// Sums audible operator slots over one frame and emits a saturated sample.
module jtopl_opacc #(
    parameter int SLOTS = 18,
    parameter int GAIN  = 0,
    parameter int ACCW  = 18
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cenop,
    input  logic               zero,
    input  logic signed [12:0] op_result,
    input  logic               op_out,
    input  logic               con,
    input  logic               clr_err,
    output logic signed [15:0] snd,
    output logic               snd_valid,
    output logic               sync_err
);

    // Shifting happens three bits wider so GAIN up to 3 never drops bits.
    localparam int EXTW = ACCW + 3;

    localparam logic signed [EXTW-1:0] SAT_HI = EXTW'(32767);
    localparam logic signed [EXTW-1:0] SAT_LO = EXTW'(-32768);

    localparam logic [4:0] CNT_MAX = 5'd31;
    localparam logic [4:0] SLOTS_C = 5'(SLOTS);
    localparam logic [1:0] GAIN_C  = 2'(GAIN);

    // Registered state
    logic signed [ACCW-1:0] acc_q, acc_d;
    logic signed [15:0]     snd_q, snd_d;
    logic                   snd_valid_q, snd_valid_d;
    logic                   sync_err_q, sync_err_d;
    logic [4:0]             slot_cnt_q, slot_cnt_d;
    logic                   synced_q, synced_d;

    // Combinational helpers
    logic                   new_frame;
    logic                   audible;
    logic signed [ACCW-1:0] contrib;
    logic signed [EXTW-1:0] acc_ext;
    logic signed [EXTW-1:0] acc_shl;
    logic signed [15:0]     sat_val;
    logic                   len_bad;
    logic                   err_set;
    logic [4:0]             cnt_inc;

    // Slot qualification and audible contribution of the current operator.
    always_comb begin
        new_frame = cenop & zero;
        audible   = op_out | con;
        contrib   = '0;
        if (audible) begin
            contrib = {{(ACCW-13){op_result[12]}}, op_result};
        end
    end

    // Gain shift and 16-bit clamp of the completed frame sum.
    always_comb begin
        acc_ext = {{3{acc_q[ACCW-1]}}, acc_q};
        acc_shl = acc_ext <<< GAIN_C;
        if (acc_shl > SAT_HI) begin
            sat_val = 16'sh7fff;
        end else if (acc_shl < SAT_LO) begin
            sat_val = 16'sh8000;
        end else begin
            sat_val = acc_shl[15:0];
        end
    end

    // Frame length tracking: saturating slot counter and error detection.
    always_comb begin
        cnt_inc = (slot_cnt_q == CNT_MAX) ? CNT_MAX : slot_cnt_q + 5'd1;
        len_bad = (slot_cnt_q != SLOTS_C);
        err_set = new_frame & synced_q & len_bad;
    end

    // Next-state for accumulator, sample and frame tracking.
    always_comb begin
        acc_d       = acc_q;
        snd_d       = snd_q;
        slot_cnt_d  = slot_cnt_q;
        synced_d    = synced_q;
        snd_valid_d = new_frame;
        if (cenop) begin
            if (zero) begin
                snd_d      = sat_val;
                acc_d      = contrib;
                slot_cnt_d = 5'd1;
                synced_d   = 1'b1;
            end else begin
                acc_d      = acc_q + contrib;
                slot_cnt_d = cnt_inc;
            end
        end
    end

    // Sticky error flag; clearing wins over a simultaneous set.
    always_comb begin
        sync_err_d = sync_err_q;
        if (clr_err) begin
            sync_err_d = 1'b0;
        end else if (err_set) begin
            sync_err_d = 1'b1;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q       <= '0;
            snd_q       <= '0;
            snd_valid_q <= 1'b0;
            sync_err_q  <= 1'b0;
            slot_cnt_q  <= '0;
            synced_q    <= 1'b0;
        end else begin
            acc_q       <= acc_d;
            snd_q       <= snd_d;
            snd_valid_q <= snd_valid_d;
            sync_err_q  <= sync_err_d;
            slot_cnt_q  <= slot_cnt_d;
            synced_q    <= synced_d;
        end
    end

    assign snd       = snd_q;
    assign snd_valid = snd_valid_q;
    assign sync_err  = sync_err_q;

endmodule

// File: tb/tb_jtopl_opacc.sv
// tb_jtopl_opacc: self-checking bench for the operator accumulator.
// Table vectors, directed corner sequences and a randomized frame stream.
module tb_jtopl_opacc;

    localparam int SLOTS = 18;
    localparam int GAIN  = 0;
    localparam int ACCW  = 18;

    logic               clk = 1'b0;
    logic               rst;
    logic               cenop;
    logic               zero;
    logic signed [12:0] op_result;
    logic               op_out;
    logic               con;
    logic               clr_err;
    logic signed [15:0] snd;
    logic               snd_valid;
    logic               sync_err;

    always #5 clk = ~clk;

    jtopl_opacc #(
        .SLOTS(SLOTS),
        .GAIN (GAIN),
        .ACCW (ACCW)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .cenop    (cenop),
        .zero     (zero),
        .op_result(op_result),
        .op_out   (op_out),
        .con      (con),
        .clr_err  (clr_err),
        .snd      (snd),
        .snd_valid(snd_valid),
        .sync_err (sync_err)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: list of contributions of the frame in progress.
    int frame_q[$];
    bit m_synced;
    int m_snd;
    bit m_val;
    bit m_err;

    typedef struct {
        bit z;
        int r;
        bit oo;
        bit cn;
        bit clr;
        int e_snd;
        bit e_val;
        bit e_err;
    } vec_t;

    vec_t tbl[8];

    function automatic int sat16(longint v);
        longint s;
        s = v * (longint'(1) << GAIN);
        if (s > 32767) return 32767;
        if (s < -32768) return -32768;
        return int'(s);
    endfunction

    function automatic int frame_sum();
        longint s = 0;
        foreach (frame_q[i]) s += frame_q[i];
        return sat16(s);
    endfunction

    task automatic chk(string nm, int act, int exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    task automatic check_all(string nm);
        chk({nm, " snd"}, int'(snd), m_snd);
        chk({nm, " snd_valid"}, int'(snd_valid), int'(m_val));
        chk({nm, " sync_err"}, int'(sync_err), int'(m_err));
    endtask

    task automatic idle_inputs();
        cenop     = 1'b0;
        zero      = 1'b0;
        op_result = '0;
        op_out    = 1'b0;
        con       = 1'b0;
        clr_err   = 1'b0;
    endtask

    task automatic drive(bit z, int r, bit oo, bit cn, bit clr);
        cenop     = 1'b1;
        zero      = z;
        op_result = r[12:0];
        op_out    = oo;
        con       = cn;
        clr_err   = clr;
    endtask

    // One cenop slot, applied to DUT and model, then checked.
    task automatic slot(bit z, int r, bit oo, bit cn, bit clr);
        int c;
        drive(z, r, oo, cn, clr);
        c = (oo || cn) ? r : 0;
        if (z) begin
            m_snd = frame_sum();
            m_val = 1'b1;
            if (m_synced && frame_q.size() != SLOTS) m_err = 1'b1;
            frame_q.delete();
            frame_q.push_back(c);
            m_synced = 1'b1;
        end else begin
            frame_q.push_back(c);
            m_val = 1'b0;
        end
        if (clr) m_err = 1'b0;
        @(posedge clk);
        #1;
        check_all(z ? "zero_slot" : "slot");
        idle_inputs();
    endtask

    // cenop low cycles; zero is held high to show it is ignored.
    task automatic gap(int n, bit clr);
        for (int i = 0; i < n; i++) begin
            cenop   = 1'b0;
            zero    = 1'b1;
            clr_err = clr;
            m_val   = 1'b0;
            if (clr) m_err = 1'b0;
            @(posedge clk);
            #1;
            check_all("gap");
        end
        idle_inputs();
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        frame_q.delete();
        m_synced = 1'b0;
        m_snd    = 0;
        m_val    = 1'b0;
        m_err    = 1'b0;
        check_all("reset");
    endtask

    // mode 0: all audible; 1: even slots muted; 2: even slots via con.
    task automatic slot_m(bit z, int idx, int r, int mode);
        bit ev;
        ev = (idx % 2) == 0;
        if (mode == 0 || !ev) slot(z, r, 1'b1, 1'b0, 1'b0);
        else if (mode == 1) slot(z, r, 1'b0, 1'b0, 1'b0);
        else slot(z, r, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic zs(int r, int mode);
        slot_m(1'b1, 0, r, mode);
    endtask

    task automatic body(int n, int r, int mode);
        for (int i = 1; i <= n; i++) slot_m(1'b0, i, r, mode);
    endtask

    initial begin
        rst = 1'b0;
        idle_inputs();
        tbl[0] = '{1, 5,     1, 0, 0, 0,     1, 0};
        tbl[1] = '{1, 7,     1, 0, 0, 5,     1, 1};
        tbl[2] = '{0, 3,     0, 0, 0, 5,     0, 1};
        tbl[3] = '{0, 2,     1, 0, 1, 5,     0, 0};
        tbl[4] = '{1, 0,     1, 0, 0, 9,     1, 1};
        tbl[5] = '{1, 1,     0, 1, 1, 0,     1, 0};
        tbl[6] = '{0, -4096, 0, 1, 0, 0,     0, 0};
        tbl[7] = '{1, 0,     1, 0, 0, -4095, 1, 1};

        repeat (2) @(posedge clk);
        #1;
        do_reset();

        for (int i = 0; i < 8; i++) begin
            drive(tbl[i].z, tbl[i].r, tbl[i].oo, tbl[i].cn, tbl[i].clr);
            @(posedge clk);
            #1;
            chk($sformatf("tbl%0d snd", i), int'(snd), tbl[i].e_snd);
            chk($sformatf("tbl%0d valid", i), int'(snd_valid),
                int'(tbl[i].e_val));
            chk($sformatf("tbl%0d err", i), int'(sync_err),
                int'(tbl[i].e_err));
        end
        idle_inputs();

        do_reset();
        zs(100, 0);
        body(17, 100, 0);
        zs(100, 0);
        chk("sum_1800", int'(snd), 1800);
        chk("sum_1800 err", int'(sync_err), 0);
        gap(1, 1'b0);
        chk("valid_one_cycle", int'(snd_valid), 0);
        body(17, 100, 0);
        zs(100, 1);
        body(17, 100, 1);
        zs(100, 2);
        chk("muted_900", int'(snd), 900);
        body(17, 100, 2);
        zs(100, 0);
        chk("con_1800", int'(snd), 1800);

        body(17, 100, 0);
        zs(4095, 0);
        body(17, 4095, 0);
        zs(-4096, 0);
        chk("sat_hi", int'(snd), 32767);
        body(17, -4096, 0);
        zs(10, 0);
        chk("sat_lo", int'(snd), -32768);
        chk("sat err", int'(sync_err), 0);

        body(16, 10, 0);
        zs(10, 0);
        chk("short_frame err", int'(sync_err), 1);
        body(17, 10, 0);
        zs(10, 0);
        chk("sticky err", int'(sync_err), 1);
        body(3, 10, 0);
        slot(1'b1, 10, 1'b1, 1'b0, 1'b1);
        chk("clr_wins err", int'(sync_err), 0);

        body(2, 1, 0);
        zs(0, 0);
        chk("err_again", int'(sync_err), 1);
        gap(1, 1'b1);
        chk("clr_no_cenop", int'(sync_err), 0);

        body(5, 10, 0);
        do_reset();
        body(3, 10, 0);
        zs(0, 0);
        chk("rst_mid snd", int'(snd), 30);
        chk("rst_mid err", int'(sync_err), 0);

        for (int i = 1; i <= 17; i++) begin
            slot(1'b0, 20, 1'b1, 1'b0, 1'b0);
            if (i % 5 == 0) gap(3, 1'b0);
        end
        zs(0, 0);
        chk("gap_sum", int'(snd), 340);

        for (int f = 0; f < 40; f++) begin
            int len;
            len = ($urandom_range(0, 4) == 0) ? int'($urandom_range(15, 21))
                                              : SLOTS;
            for (int s = 0; s < len; s++) begin
                int r;
                r = int'($urandom_range(0, 8191)) - 4096;
                slot(s == 0, r, 1'($urandom_range(0, 1)),
                     1'($urandom_range(0, 1)),
                     $urandom_range(0, 30) == 0);
                if ($urandom_range(0, 9) == 0)
                    gap(int'($urandom_range(1, 3)),
                        $urandom_range(0, 5) == 0);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
